// File: rtl/bus_dma_master.sv
// bus_dma_master: single-channel DMA engine doing word copy, constant fill and responder clear
// over a simple one-cycle select/load bus.
module bus_dma_master #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_sel,
  output logic              mem_ld,
  output logic              mem_clr
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, CLR, FIN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] src_r, dst_r, len_r, i, i_n, src_l, dst_l, addr_n;
  logic [DATA_W-1:0] fill_r, fill_l, buf_r, buf_n, wdata_n;
  logic [1:0] mode_r, mode_l;
  logic launch, live, last, fail;
  logic busy_n, done_n, err_n, sel_n, ld_n, clr_n;
  assign launch = state == IDLE && start;
  assign live = state inside {RD, CAP, WR, CLR};
  assign last = i + ADDR_W'(1) == len_r;
  // job parameters as seen by the next cycle, so outputs can be registered from the launch edge
  assign src_l = launch ? src_addr : src_r;
  assign dst_l = launch ? dst_addr : dst_r;
  assign fill_l = launch ? fill_value : fill_r;
  assign mode_l = launch ? mode : mode_r;
  always_ff @(posedge clk or negedge res)
    if (!res) begin
      state <= IDLE;
      i <= '0;
      buf_r <= '0;
      src_r <= '0;
      dst_r <= '0;
      len_r <= '0;
      fill_r <= '0;
      mode_r <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      mem_sel <= 1'b0;
      mem_ld <= 1'b1;
      mem_clr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      i <= i_n;
      buf_r <= buf_n;
      src_r <= src_l;
      dst_r <= dst_l;
      len_r <= launch ? len : len_r;
      fill_r <= fill_l;
      mode_r <= mode_l;
      busy <= busy_n;
      done <= done_n;
      err <= err_n;
      mem_sel <= sel_n;
      mem_ld <= ld_n;
      mem_clr <= clr_n;
      mem_addr <= addr_n;
      mem_wdata <= wdata_n;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = mode == 2'b11 ? FIN : mode == 2'b10 ? CLR : len == '0 ? FIN : mode == 2'b00 ? RD : WR;
      RD: state_n = CAP;
      CAP: state_n = WR;
      WR: state_n = last ? FIN : mode_r == 2'b00 ? RD : WR;
      CLR: state_n = FIN;
      default: state_n = IDLE;
    endcase
    if (live && abort) state_n = FIN;
  end
  // outputs are precomputed from the next state and registered
  always_comb begin
    i_n = launch ? '0 : state == WR ? i + ADDR_W'(1) : i;
    buf_n = state == CAP ? mem_rdata : buf_r;
    fail = (launch && mode == 2'b11) || (live && abort);
    busy_n = state_n inside {RD, CAP, WR, CLR};
    done_n = state_n == FIN && !fail;
    err_n = state_n == FIN && fail;
    sel_n = state_n inside {RD, WR};
    ld_n = state_n != WR;
    clr_n = state_n == CLR;
    addr_n = state_n == RD ? src_l + i_n : state_n == WR ? dst_l + i_n : '0;
    wdata_n = state_n != WR ? '0 : mode_l == 2'b00 ? buf_n : fill_l;
  end
endmodule

// File: tb/tb_bus_dma_master.sv
// tb_bus_dma_master: directed and random DMA jobs against a word-level memory model.
module tb_bus_dma_master;
  localparam int AW = 12, DW = 16;
  logic clk = 1'b0, res = 1'b0, start = 1'b0, abort = 1'b0;
  logic [1:0] mode = '0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0, len = '0;
  logic [DW-1:0] fill_value = '0;
  logic busy, done, err, mem_sel, mem_ld, mem_clr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [27:0] q_exp[$], q_obs[$];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  bus_dma_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .res(res), .start(start), .abort(abort), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_value(fill_value),
    .busy(busy), .done(done), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_sel(mem_sel), .mem_ld(mem_ld), .mem_clr(mem_clr)
  );
  always @(posedge clk) begin
    if (mem_sel && !mem_ld) mem[mem_addr] <= mem_wdata;
    if (mem_sel && mem_ld) mem_rdata <= mem[mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_job(input logic [1:0] m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW-1:0] l, input logic [DW-1:0] f, input int ab,
                         input bit jit, input bit sab, input string tag);
    int eb, ed, ee, ec, nw, nb, nd, ne, nc, bad, nwr;
    bit fin, aborted;
    logic [AW-1:0] a, r;
    logic [DW-1:0] v;
    aborted = ab > 0 && ab <= int'(l) && m < 2;
    eb = 0; ed = 1; ee = 0; ec = 0; nw = 0;
    q_exp.delete();
    q_obs.delete();
    if (m == 2'b11) begin ed = 0; ee = 1; end
    else if (m == 2'b10) begin eb = 1; ec = 1; end
    else if (l != 0) begin
      nw = aborted ? ab : int'(l);
      for (int k = 0; k < nw; k++) begin
        a = d + AW'(k);
        r = s + AW'(k);
        v = m == 2'b00 ? ref_mem[r] : f;
        ref_mem[a] = v;
        q_exp.push_back({a, v});
      end
      eb = m == 2'b00 ? 3 * nw : nw;
      if (aborted) begin ed = 0; ee = 1; end
    end
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; len = l; fill_value = f; start = 1'b1; abort = sab;
    @(negedge clk);
    nb = 0; nd = 0; ne = 0; nc = 0; bad = 0; nwr = 0; fin = 0;
    for (int c = 0; c < 100 && !fin; c++) begin
      start = 1'b0;
      abort = 1'b0;
      if (busy) nb++;
      if (mem_clr) nc++;
      if (mem_clr && mem_sel) bad++;
      if (!mem_sel && !mem_ld) bad++;
      if ((!mem_sel || mem_ld) && mem_wdata != '0) bad++;
      if (done || err) begin
        nd += int'(done); ne += int'(err); fin = 1;
        chk({tag, "/fin_busy"}, busy, 0);
      end else begin
        if (mem_sel && !mem_ld) begin
          q_obs.push_back({mem_addr, mem_wdata});
          nwr++;
          if (nwr == ab) abort = 1'b1;
        end
        if (jit && busy) begin
          start = 1'($urandom); mode = 2'($urandom); src_addr = AW'($urandom);
          dst_addr = AW'($urandom); len = AW'($urandom); fill_value = DW'($urandom);
        end
        @(negedge clk);
      end
    end
    chk({tag, "/timeout"}, fin, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk({tag, "/after"}, {busy, done, err, mem_sel}, 0);
    chk({tag, "/busy"}, nb, eb);
    chk({tag, "/done"}, nd, ed);
    chk({tag, "/err"}, ne, ee);
    chk({tag, "/clr"}, nc, ec);
    chk({tag, "/bus_rules"}, bad, 0);
    chk({tag, "/nwr"}, q_obs.size(), q_exp.size());
    for (int k = 0; k < q_obs.size() && k < q_exp.size(); k++) chk({tag, "/wr"}, q_obs[k], q_exp[k]);
  endtask
  initial begin
    logic [1:0] m;
    logic [AW-1:0] l;
    int ab, idle;
    for (int k = 0; k < (1 << AW); k++) begin
      mem[k] = DW'($urandom);
      ref_mem[k] = mem[k];
    end
    for (int k = 0; k < 3; k++) begin
      mem[2 + k] = DW'(16'h1111 * (k + 1));
      ref_mem[2 + k] = mem[2 + k];
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sel", mem_sel, 0);
    chk("rst_ld", mem_ld, 1);
    chk("rst_clr", mem_clr, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    res = 1'b1;
    run_job(2'b00, 12'd2, 12'd40, 12'd3, 16'h0, 0, 0, 0, "copy");
    chk("copy_40", mem[40], 16'h1111);
    chk("copy_42", mem[42], 16'h3333);
    run_job(2'b01, 12'h0, 12'd110, 12'd1, 16'hBEEF, 0, 0, 0, "fill");
    run_job(2'b01, 12'h0, 12'hFFE, 12'd3, 16'h1234, 0, 0, 0, "wrap");
    run_job(2'b10, 12'h5, 12'h6, 12'd4, 16'h0, 0, 0, 0, "clear");
    run_job(2'b00, 12'h10, 12'h20, 12'd0, 16'h0, 0, 0, 0, "len0_copy");
    run_job(2'b01, 12'h10, 12'h20, 12'd0, 16'h55, 0, 0, 0, "len0_fill");
    run_job(2'b11, 12'h10, 12'h20, 12'd4, 16'h55, 0, 0, 0, "reserved");
    run_job(2'b00, 12'h300, 12'h310, 12'd2, 16'h0, 0, 0, 1, "start_wins");
    run_job(2'b00, 12'h100, 12'h200, 12'd10, 16'h0, 4, 0, 0, "abort_copy");
    run_job(2'b01, 12'h100, 12'h400, 12'd6, 16'hA5A5, 2, 0, 0, "abort_fill");
    for (int n = 0; n < 24; n++) begin
      m = 2'($urandom);
      l = AW'($urandom_range(0, 8));
      ab = (m < 2 && l != 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, int'(l))) : 0;
      run_job(m, AW'($urandom), AW'($urandom), l, DW'($urandom), ab, 1, 0, "rnd");
    end
    @(negedge clk);
    mode = 2'b00; src_addr = 12'd500; dst_addr = 12'd600; len = 12'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    res = 1'b0;
    #1;
    chk("midrst_flags", {busy, done, err, mem_sel, mem_ld, mem_clr}, 6'b000010);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_wdata", mem_wdata, 0);
    @(negedge clk);
    res = 1'b1;
    idle = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || done || err || mem_sel || mem_clr) idle++;
    end
    chk("midrst_quiet", idle, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_dma_master.md
BUS_DMA_MASTER -- requirements
Module: bus_dma_master

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 12, bus address width; DATA_W, default 16, bus data width.
REQ-002 clk  input  1  system clock; every register updates on the rising edge.
REQ-003 res  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  launches a job when sampled high in IDLE.
REQ-005 abort  input  1  cancels the active job.
REQ-006 mode  input  2  job type: 00=copy, 01=fill, 10=clear, 11=reserved.
REQ-007 src_addr  input  ADDR_W  copy source base address.
REQ-008 dst_addr  input  ADDR_W  copy or fill destination base address.
REQ-009 len  input  ADDR_W  word count.
REQ-010 fill_value  input  DATA_W  constant written in fill mode.
REQ-011 busy  output  1  high while a job is active.
REQ-012 done  output  1  one-cycle pulse when a job completes normally.
REQ-013 err  output  1  one-cycle pulse on a reserved mode or an abort.
REQ-014 mem_addr  output  ADDR_W  bus address.
REQ-015 mem_wdata  output  DATA_W  bus write data.
REQ-016 mem_rdata  input  DATA_W  bus read data from the responder.
REQ-017 mem_sel  output  1  bus chip select.
REQ-018 mem_ld  output  1  bus direction: 1=load (read), 0=store (write).
REQ-019 mem_clr  output  1  responder clear strobe.

Function
REQ-020 The bus protocol SHALL be:
- read: mem_sel=1 and mem_ld=1 for one cycle; mem_rdata is valid in the following cycle.
- write: mem_sel=1 and mem_ld=0 for one cycle, with mem_addr and mem_wdata stable; the responder commits at the cycle-ending edge.
REQ-021 States SHALL be IDLE, RD, CAP, WR, CLR and FIN; all state and output registers SHALL be registered.
REQ-022 In IDLE with start=1, the block SHALL latch src_addr, dst_addr, len, mode and fill_value, and set the word index i=0.
REQ-023 From IDLE with start=1, the next state SHALL be: RD for copy, WR for fill, CLR for clear.
REQ-024 From IDLE with start=1 and mode=11, the block SHALL go to FIN with err pulsed and done not pulsed.
REQ-025 If len=0 in copy or fill mode, the block SHALL go from IDLE to FIN with no bus activity, and done SHALL pulse.
REQ-026 RD SHALL drive mem_sel=1, mem_ld=1, mem_addr=src+i, then go to CAP.
REQ-027 CAP SHALL drive mem_sel=0, capture mem_rdata into a DATA_W buffer, then go to WR.
REQ-028 WR SHALL drive mem_sel=1, mem_ld=0, mem_addr=dst+i, and mem_wdata = buffer (copy) or fill_value (fill).
REQ-029 In WR, the block SHALL increment i; if the new i equals len it SHALL go to FIN, otherwise to RD (copy) or stay in WR (fill).
REQ-030 Throughput SHALL be 3 cycles per word for copy and 1 cycle per word for fill.
REQ-031 Address sums SHALL be computed modulo 2^ADDR_W, wrapping from 0xFFF to 0x000 with no error.
REQ-032 CLR SHALL assert mem_clr for exactly one cycle with mem_sel=0, then go to FIN.
REQ-033 FIN SHALL last one cycle with busy=0 and pulse done (or err, per REQ-024 and REQ-035), then go to IDLE.
REQ-034 busy SHALL be 1 in RD, CAP, WR and CLR, and 0 in IDLE and FIN.
REQ-035 abort=1 in any busy state SHALL force the next state to FIN with err pulsed and done not pulsed, and mem_sel=0 and mem_clr=0 from that edge onward.
REQ-036 A write already presented in the cycle in which abort is sampled SHALL complete.
REQ-037 abort SHALL be ignored in IDLE and FIN.
REQ-038 start SHALL be ignored while busy=1 and in FIN.
REQ-039 When start and abort are both high in IDLE, start SHALL win.
REQ-040 mem_ld SHALL be 1 whenever mem_sel=0; mem_wdata SHALL be 0 outside WR.

Reset
REQ-041 res=0 SHALL immediately force state=IDLE.
REQ-042 During reset, the outputs SHALL be busy=0, done=0, err=0, mem_sel=0, mem_ld=1, mem_clr=0, mem_addr=0 and mem_wdata=0; the index and buffer SHALL also be 0.
REQ-043 Reset asserted mid-job SHALL abandon the job with no done or err pulse.
REQ-044 After reset is released, the block SHALL idle until the next start.

Verification
REQ-045 Copy: memory[2..4]=0x1111/0x2222/0x3333, start with mode=00, src=2, dst=40, len=3 -> writes at 40/41/42 carry those values, busy high for 9 cycles, done pulses once.
REQ-046 Fill: mode=01, dst=110, len=1, fill=0xBEEF -> a single write to address 110 with data 0xBEEF, done one cycle later.
REQ-047 Wrap: mode=01, dst=0xFFE, len=3 -> writes hit 0xFFE, 0xFFF, 0x000, err stays 0.
REQ-048 Clear: mode=10 -> mem_clr high for exactly 1 cycle, mem_sel stays 0, done pulses.
REQ-049 Abort: copy with len=10, abort raised in the 4th WR cycle -> that write completes, no further mem_sel, err pulses, done stays 0.
REQ-050 Edge cases: len=0 -> done with no mem_sel; mode=11 -> err; res low mid-copy -> all outputs at reset values at once, no pulse on release.
